// File: rtl/core_cluster_ctrl.sv
// Core cluster controller: boots core 0, then arbitrates spawn requests from
// running cores onto idle cores and tracks when the whole cluster has finished.
// All outputs come straight from registers.
module core_cluster_ctrl #(
   parameter int unsigned NUM_CORES = 2,
   parameter int unsigned PC_W      = 32
) (
   input  logic                      sclk,
   input  logic                      reset,
   input  logic                      load,
   input  logic [PC_W-1:0]           boot_pc,
   input  logic [NUM_CORES-1:0]      spawn_req,
   input  logic [NUM_CORES*PC_W-1:0] spawn_pc,
   input  logic [NUM_CORES-1:0]      exit_req,
   output logic [NUM_CORES-1:0]      spawn_ack,
   output logic [NUM_CORES-1:0]      wake,
   output logic [NUM_CORES-1:0]      pc_load,
   output logic [NUM_CORES*PC_W-1:0] wake_pc,
   output logic [NUM_CORES-1:0]      busy,
   output logic                      all_done
);

   localparam int unsigned IDX_W = $clog2(NUM_CORES);

   typedef enum logic [1:0] {StIdle, StBoot, StRun, StDone} state_e;

   state_e                    state_q, state_d;
   logic [NUM_CORES-1:0]      busy_q, busy_d;
   logic [NUM_CORES-1:0]      wake_q, wake_d;
   logic [NUM_CORES-1:0]      pc_load_q, pc_load_d;
   logic [NUM_CORES-1:0]      ack_q, ack_d;
   logic [NUM_CORES*PC_W-1:0] wake_pc_q, wake_pc_d;
   logic [IDX_W-1:0]          ptr_q, ptr_d;

   logic [NUM_CORES-1:0]      exit_eff;
   logic [NUM_CORES-1:0]      eligible;
   logic                      req_found;
   logic [IDX_W-1:0]          req_idx;
   logic [IDX_W-1:0]          cand;
   logic                      tgt_found;
   logic [IDX_W-1:0]          tgt_idx;
   logic [PC_W-1:0]           req_pc;
   logic                      grant;

   // Arbitration: round-robin requester among busy, non-exiting cores; target is
   // the lowest core idle at this edge (a core exiting now is still busy here).
   always_comb begin
      exit_eff  = exit_req & busy_q;
      eligible  = spawn_req & busy_q & ~exit_eff;
      req_found = 1'b0;
      req_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NUM_CORES; k++) begin
         cand = IDX_W'((int'(ptr_q) + k) % NUM_CORES);
         if (!req_found && eligible[cand]) begin
            req_found = 1'b1;
            req_idx   = cand;
         end
      end
      tgt_found = 1'b0;
      tgt_idx   = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (!busy_q[i]) begin
            tgt_found = 1'b1;
            tgt_idx   = IDX_W'(i);
         end
      end
      req_pc = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (req_idx == IDX_W'(i)) req_pc = spawn_pc[i*PC_W +: PC_W];
      end
      grant = req_found && tgt_found;
   end

   // Next-state and next-output logic; pulses default to zero every cycle.
   always_comb begin
      state_d   = state_q;
      busy_d    = busy_q;
      wake_d    = '0;
      pc_load_d = '0;
      ack_d     = '0;
      wake_pc_d = wake_pc_q;
      ptr_d     = ptr_q;
      unique case (state_q)
         StIdle: begin
            if (!load) state_d = StBoot;
         end
         StBoot: begin
            state_d                = StRun;
            wake_d[0]              = 1'b1;
            pc_load_d[0]           = 1'b1;
            busy_d                 = NUM_CORES'(1);
            wake_pc_d[PC_W-1:0]    = boot_pc;
         end
         StRun: begin
            if (load) begin
               // Abort: everything stops, pending requests are simply not granted.
               state_d = StIdle;
               busy_d  = '0;
            end else if (busy_q == '0) begin
               state_d = StDone;
            end else begin
               busy_d = busy_q & ~exit_eff;
               if (grant) begin
                  ack_d[req_idx]     = 1'b1;
                  wake_d[tgt_idx]    = 1'b1;
                  pc_load_d[tgt_idx] = 1'b1;
                  busy_d[tgt_idx]    = 1'b1;
                  for (int i = 0; i < NUM_CORES; i++) begin
                     if (tgt_idx == IDX_W'(i)) wake_pc_d[i*PC_W +: PC_W] = req_pc;
                  end
                  ptr_d = (req_idx == IDX_W'(NUM_CORES - 1)) ? '0 : req_idx + 1'b1;
               end
            end
         end
         StDone: begin
            if (load) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge sclk) begin
      if (reset) begin
         state_q   <= StIdle;
         busy_q    <= '0;
         wake_q    <= '0;
         pc_load_q <= '0;
         ack_q     <= '0;
         wake_pc_q <= '0;
         ptr_q     <= '0;
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         wake_q    <= wake_d;
         pc_load_q <= pc_load_d;
         ack_q     <= ack_d;
         wake_pc_q <= wake_pc_d;
         ptr_q     <= ptr_d;
      end
   end

   assign spawn_ack = ack_q;
   assign wake      = wake_q;
   assign pc_load   = pc_load_q;
   assign wake_pc   = wake_pc_q;
   assign busy      = busy_q;
   assign all_done  = (state_q == StDone);

endmodule

// File: tb/tb_core_cluster_ctrl.sv
// Directed bench for core_cluster_ctrl: a 2-core and a 4-core instance driven
// in sequence, expected values written out by hand.
module tb_core_cluster_ctrl;

   localparam int unsigned PW = 32;

   logic sclk;
   initial sclk = 1'b0;
   always #5 sclk = ~sclk;

   // 2-core instance
   logic          reset2, load2;
   logic [PW-1:0] boot_pc2;
   logic [1:0]    spawn_req2, exit_req2, ack2, wake2, pcl2, busy2;
   logic [2*PW-1:0] spawn_pc2, wake_pc2;
   logic          done2;

   // 4-core instance
   logic          reset4, load4;
   logic [PW-1:0] boot_pc4;
   logic [3:0]    spawn_req4, exit_req4, ack4, wake4, pcl4, busy4;
   logic [4*PW-1:0] spawn_pc4, wake_pc4;
   logic          done4;

   int vectors = 0;
   int errs    = 0;

   core_cluster_ctrl #(.NUM_CORES(2), .PC_W(PW)) dut2 (
      .sclk(sclk), .reset(reset2), .load(load2), .boot_pc(boot_pc2),
      .spawn_req(spawn_req2), .spawn_pc(spawn_pc2), .exit_req(exit_req2),
      .spawn_ack(ack2), .wake(wake2), .pc_load(pcl2), .wake_pc(wake_pc2),
      .busy(busy2), .all_done(done2)
   );

   core_cluster_ctrl #(.NUM_CORES(4), .PC_W(PW)) dut4 (
      .sclk(sclk), .reset(reset4), .load(load4), .boot_pc(boot_pc4),
      .spawn_req(spawn_req4), .spawn_pc(spawn_pc4), .exit_req(exit_req4),
      .spawn_ack(ack4), .wake(wake4), .pc_load(pcl4), .wake_pc(wake_pc4),
      .busy(busy4), .all_done(done4)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge sclk);
      #1;
   endtask

   initial begin
      reset2 = 1'b1; load2 = 1'b1; boot_pc2 = 32'h100;
      spawn_req2 = '0; exit_req2 = '0; spawn_pc2 = '0;
      reset4 = 1'b1; load4 = 1'b1; boot_pc4 = 32'h40;
      spawn_req4 = '0; exit_req4 = '0; spawn_pc4 = '0;

      // ---------------- 2-core instance ----------------
      step();
      chk("rst_busy", busy2, 2'b00);
      chk("rst_wake", wake2, 2'b00);
      chk("rst_ack", ack2, 2'b00);
      chk("rst_wpc", wake_pc2, '0);
      chk("rst_done", done2, 1'b0);

      reset2 = 1'b0;
      step();
      chk("idle_hold_wake", wake2, 2'b00);

      // boot
      load2 = 1'b0;
      step();
      chk("boot_e1_wake", wake2, 2'b00);
      chk("boot_e1_busy", busy2, 2'b00);
      step();
      chk("boot_wake", wake2, 2'b01);
      chk("boot_pcl", pcl2, 2'b01);
      chk("boot_wpc0", wake_pc2[31:0], 32'h100);
      chk("boot_busy", busy2, 2'b01);

      // spawn core0 -> core1
      spawn_req2 = 2'b01; spawn_pc2[31:0] = 32'h200;
      step();
      chk("spawn_ack", ack2, 2'b01);
      chk("spawn_wake", wake2, 2'b10);
      chk("spawn_pcl", pcl2, 2'b10);
      chk("spawn_wpc1", wake_pc2[63:32], 32'h200);
      chk("spawn_busy", busy2, 2'b11);
      spawn_req2 = 2'b00;
      step();
      chk("post_spawn_ack", ack2, 2'b00);
      chk("post_spawn_wake", wake2, 2'b00);

      // full: core1 requests while both busy
      spawn_req2 = 2'b10; spawn_pc2[63:32] = 32'h300;
      step();
      chk("full_ack1", ack2, 2'b00);
      step();
      chk("full_ack2", ack2, 2'b00);
      exit_req2 = 2'b01;
      step();
      chk("exit_busy", busy2, 2'b10);
      chk("exit_ack", ack2, 2'b00);
      exit_req2 = 2'b00;
      step();
      chk("full_grant_ack", ack2, 2'b10);
      chk("full_grant_wake", wake2, 2'b01);
      chk("full_grant_wpc0", wake_pc2[31:0], 32'h300);
      chk("full_grant_busy", busy2, 2'b11);
      spawn_req2 = 2'b00;

      // done: both exit at once
      exit_req2 = 2'b11;
      step();
      chk("alldone_busy", busy2, 2'b00);
      chk("alldone_early", done2, 1'b0);
      exit_req2 = 2'b00;
      step();
      chk("alldone_set", done2, 1'b1);
      step();
      chk("alldone_hold", done2, 1'b1);
      load2 = 1'b1;
      step();
      chk("alldone_clr", done2, 1'b0);

      // reset during a grant cycle
      load2 = 1'b0;
      step();
      step();
      chk("reboot_busy", busy2, 2'b01);
      spawn_req2 = 2'b01; reset2 = 1'b1;
      step();
      chk("rstmid_ack", ack2, 2'b00);
      chk("rstmid_wake", wake2, 2'b00);
      chk("rstmid_pcl", pcl2, 2'b00);
      chk("rstmid_busy", busy2, 2'b00);
      chk("rstmid_wpc", wake_pc2, '0);
      reset2 = 1'b0; spawn_req2 = 2'b00; load2 = 1'b1;
      step();
      chk("rstmid_after_wake", wake2, 2'b00);

      // ---------------- 4-core instance ----------------
      reset4 = 1'b0; load4 = 1'b0;
      step();
      step();
      chk("b4_wake", wake4, 4'b0001);
      chk("b4_busy", busy4, 4'b0001);
      chk("b4_wpc0", wake_pc4[31:0], 32'h40);

      spawn_req4 = 4'b0001; spawn_pc4[31:0] = 32'ha0;
      step();
      chk("s4a_ack", ack4, 4'b0001);
      chk("s4a_wake", wake4, 4'b0010);
      chk("s4a_busy", busy4, 4'b0011);
      spawn_req4 = 4'b0010; spawn_pc4[63:32] = 32'hb0;
      step();
      chk("s4b_ack", ack4, 4'b0010);
      chk("s4b_wake", wake4, 4'b0100);
      chk("s4b_wpc2", wake_pc4[95:64], 32'hb0);
      chk("s4b_busy", busy4, 4'b0111);
      spawn_req4 = 4'b0000; exit_req4 = 4'b0100;
      step();
      chk("x4_busy", busy4, 4'b0011);

      // round-robin: cores 0,1 both requesting, pointer now at 2
      exit_req4 = 4'b0000; spawn_req4 = 4'b0011;
      spawn_pc4[31:0] = 32'hc0; spawn_pc4[63:32] = 32'hd0;
      step();
      chk("rr1_ack", ack4, 4'b0001);
      chk("rr1_wake", wake4, 4'b0100);
      chk("rr1_wpc2", wake_pc4[95:64], 32'hc0);
      chk("rr1_busy", busy4, 4'b0111);
      step();
      chk("rr2_ack", ack4, 4'b0010);
      chk("rr2_wake", wake4, 4'b1000);
      chk("rr2_wpc3", wake_pc4[127:96], 32'hd0);
      chk("rr2_busy", busy4, 4'b1111);
      step();
      chk("rr3_full_ack", ack4, 4'b0000);

      // cores 0,3 exit; core0 request then ignored as non-busy
      exit_req4 = 4'b1001;
      step();
      chk("x4b_busy", busy4, 4'b0110);
      chk("x4b_ack", ack4, 4'b0000);
      exit_req4 = 4'b0000;
      step();
      chk("nb_ack", ack4, 4'b0010);
      chk("nb_wake", wake4, 4'b0001);
      chk("nb_wpc0", wake_pc4[31:0], 32'hd0);
      chk("nb_busy", busy4, 4'b0111);

      // exit and grant together: exiting core0 is not the target, core3 is
      exit_req4 = 4'b0001; spawn_req4 = 4'b0010; spawn_pc4[63:32] = 32'he0;
      step();
      chk("xg_ack", ack4, 4'b0010);
      chk("xg_wake", wake4, 4'b1000);
      chk("xg_wpc3", wake_pc4[127:96], 32'he0);
      chk("xg_busy", busy4, 4'b1110);

      // exit beats spawn on the same core; exit on idle core0 ignored
      exit_req4 = 4'b0011; spawn_req4 = 4'b0010;
      step();
      chk("xw_ack", ack4, 4'b0000);
      chk("xw_wake", wake4, 4'b0000);
      chk("xw_busy", busy4, 4'b1100);

      exit_req4 = 4'b0000; spawn_req4 = 4'b0000; load4 = 1'b1;
      step();
      chk("abort_busy", busy4, 4'b0000);
      chk("abort_done", done4, 1'b0);
      step();
      chk("abort_idle_wake", wake4, 4'b0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule

// File: doc/core_cluster_ctrl.md
CORE_CLUSTER_CTRL -- requirements
Module: core_cluster_ctrl

Interface
REQ-001 SHALL have parameter NUM_CORES, default 2, number of cores managed (legal 2..8).
REQ-002 SHALL have parameter PC_W, default 32, program-counter width.
REQ-003 SHALL have port sclk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port load  input  1  program-load mode; high holds every core asleep.
REQ-006 SHALL have port boot_pc  input  PC_W  start PC handed to core 0 at boot.
REQ-007 SHALL have port spawn_req  input  NUM_CORES  per-core level request to start another core.
REQ-008 SHALL have port spawn_pc  input  NUM_CORES*PC_W  per-core target PC; slice i belongs to core i.
REQ-009 SHALL have port exit_req  input  NUM_CORES  per-core single-cycle pulse: core has finished.
REQ-010 SHALL have port spawn_ack  output  NUM_CORES  one-cycle pulse: request of core i accepted.
REQ-011 SHALL have port wake  output  NUM_CORES  one-cycle pulse: core i starts.
REQ-012 SHALL have port pc_load  output  NUM_CORES  one-cycle pulse, coincident with wake: core i loads wake_pc.
REQ-013 SHALL have port wake_pc  output  NUM_CORES*PC_W  registered start PC per core, held until next wake of that core.
REQ-014 SHALL have port busy  output  NUM_CORES  core i is running.
REQ-015 SHALL have port all_done  output  1  high in DONE state.

Function
REQ-016 SHALL implement states IDLE, BOOT, RUN, DONE.
REQ-017 IDLE: SHALL stay while load=1; on load=0 SHALL go to BOOT.
REQ-018 BOOT: SHALL last one cycle; next cycle: wake[0]=pc_load[0]=1, wake_pc[0]=boot_pc as sampled in BOOT, busy[0]=1; state -> RUN.
REQ-019 RUN: each cycle SHALL grant at most one spawn_req, chosen round-robin: the pointer starts at core 0 after reset, and after a grant points to the granted requester+1 mod NUM_CORES.
REQ-020 Only requests from cores with busy=1 SHALL be eligible; spawn_req from a non-busy core SHALL be ignored.
REQ-021 Target SHALL be the lowest-index core with busy=0 at the sampling edge; if no core is idle, no grant occurs and the request stays pending (no ack, no drop).
REQ-022 Grant latency: request sampled at edge t -> at t+1 spawn_ack[req]=1, wake[tgt]=pc_load[tgt]=1, wake_pc[tgt]=spawn_pc slice of requester, busy[tgt]=1.
REQ-023 Requester SHALL deassert spawn_req the cycle after spawn_ack; a still-high request is treated as a new request.
REQ-024 exit_req[i] with busy[i]=1 SHALL clear busy[i] at the next edge; exit_req on a non-busy core SHALL be ignored.
REQ-025 A core asserting exit_req and spawn_req in the same cycle: exit SHALL win; its spawn_req is ignored that cycle.
REQ-026 Exit and grant in the same cycle: the exiting core SHALL NOT be a spawn target until the following cycle.
REQ-027 RUN -> DONE when busy becomes all-zero and no grant issues; all_done=1 in DONE.
REQ-028 DONE -> IDLE when load=1; load=1 in RUN SHALL force IDLE, clearing busy and dropping pending requests.
REQ-029 wake, pc_load, spawn_ack SHALL be zero in every cycle not explicitly pulsed; at most one bit of spawn_ack per cycle.
REQ-030 Outputs SHALL all be registered; no combinational path from inputs to outputs.

Reset
REQ-031 reset=1 at an edge SHALL force state IDLE, busy=0, wake=0, pc_load=0, spawn_ack=0, wake_pc=0, all_done=0, round-robin pointer=0.
REQ-032 reset SHALL override all other inputs, including mid-BOOT and mid-grant; no pulse issues on the edge following reset.

Verification
REQ-033 Boot: NUM_CORES=2, boot_pc=0x100, load 1->0 -> two edges later wake[0]=pc_load[0]=1, wake_pc[0]=0x100, busy=2'b01.
REQ-034 Spawn: core0 req, spawn_pc[0]=0x200 -> next cycle spawn_ack[0]=1, wake[1]=1, wake_pc[1]=0x200, busy=2'b11.
REQ-035 Full: NUM_CORES=2 both busy, core1 requests -> no ack until core0 exit_req; ack two cycles after exit edge; target core0.
REQ-036 Round-robin: NUM_CORES=4, cores 0,1 busy, both request every cycle -> grants alternate 0,1, targets 2 then 3.
REQ-037 Done: all busy cores exit same cycle -> next cycle busy=0, then all_done=1; load=1 -> IDLE, all_done=0.
REQ-038 Reset mid-run: reset during a pending grant cycle -> no wake pulse, all outputs zero next cycle.
